// File: rtl/audio_pkg.sv
// Shared audio definitions: channel word width and the I2S receiver state encoding.
package audio_pkg;

  // Default bits per channel word
  localparam int unsigned AUD_WIDTH = 16;

  // Receiver framing states: IDLE hunts for a left-word boundary, LEFT/RIGHT assemble words
  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } state_e;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with optional rising-edge detect.
// With HAS_EDGE = 0 no history flop is built and rise is tied low.
module i2s_sync_edge #(
  parameter int unsigned STAGES   = 2,
  parameter bit          HAS_EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchroniser chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

  if (HAS_EDGE) begin : g_edge
    logic hist_q;

    // Remember the previous synchronised level for 0->1 detection
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hist_q <= 1'b0;
      end else begin
        hist_q <= dout;
      end
    end

    assign rise = dout & ~hist_q;
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples bit_clk/frame_clk/data in the clk domain, assembles MSB-first
// words with the standard one-bit word-select delay and presents one left/right pair per
// frame with a single-cycle sample_valid strobe. Words of the wrong length are still stored
// (left-aligned, truncated or zero-padded) and flagged with a frame_err pulse.
module i2s_receiver
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH       = AUD_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_clk,
  input  logic             frame_clk,
  input  logic             data,
  output logic [WIDTH-1:0] sample_left,
  output logic [WIDTH-1:0] sample_right,
  output logic             sample_valid,
  output logic             frame_err
);

  // Counter must hold 0..WIDTH+1 (saturation value marks an over-long word)
  localparam int unsigned        CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0]   CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(WIDTH + 1);
  localparam logic [WIDTH-1:0]   MSB_ONE  = {1'b1, {(WIDTH - 1){1'b0}}};

  // Synchronised inputs
  logic bclk_rise;
  logic ws_s;
  logic sd_s;
  logic bclk_level_unused;
  logic ws_rise_unused;
  logic sd_rise_unused;

  // FSM
  state_e state_q;
  state_e state_d;

  // FSM decoded strobes
  logic shift_en;
  logic word_close;
  logic load_left;
  logic load_pair;
  logic word_clear;

  // Datapath
  logic             ws_prev_q,      ws_prev_d;
  logic [WIDTH-1:0] shift_q,        shift_d;
  logic [CNT_W-1:0] cnt_q,          cnt_d;
  logic [WIDTH-1:0] left_hold_q,    left_hold_d;
  logic [WIDTH-1:0] sample_left_q,  sample_left_d;
  logic [WIDTH-1:0] sample_right_q, sample_right_d;
  logic             valid_q,        valid_d;
  logic             err_q,          err_d;

  // Word assembly helpers
  logic             ws_edge;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] closed_word;
  logic [CNT_W-1:0] cnt_inc;
  logic             closed_bad;

  // ---------------------------------------------------------------------------------------------
  // Input synchronisers; only bit_clk needs an edge detector
  // ---------------------------------------------------------------------------------------------
  i2s_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .HAS_EDGE (1'b1)
  ) u_sync_bclk (
    .clk   (clk),
    .reset (reset),
    .din   (bit_clk),
    .dout  (bclk_level_unused),
    .rise  (bclk_rise)
  );

  i2s_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .HAS_EDGE (1'b0)
  ) u_sync_ws (
    .clk   (clk),
    .reset (reset),
    .din   (frame_clk),
    .dout  (ws_s),
    .rise  (ws_rise_unused)
  );

  i2s_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .HAS_EDGE (1'b0)
  ) u_sync_sd (
    .clk   (clk),
    .reset (reset),
    .din   (data),
    .dout  (sd_s),
    .rise  (sd_rise_unused)
  );

  // A word-select change seen on a bit-clock rise carries the LSB of the outgoing word
  assign ws_edge = bclk_rise & (ws_s ^ ws_prev_q);

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: IDLE leaves only at a right->left boundary so the first pair is complete
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (bclk_rise && ws_prev_q && !ws_s) state_d = LEFT;
        LEFT:    if (ws_edge) state_d = RIGHT;
        RIGHT:   if (ws_edge) state_d = LEFT;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: decode which datapath action this cycle performs
  always_comb begin
    shift_en   = 1'b0;
    word_close = 1'b0;
    load_left  = 1'b0;
    load_pair  = 1'b0;
    if (enable) begin
      unique case (state_q)
        LEFT: begin
          shift_en   = bclk_rise & ~ws_edge;
          word_close = ws_edge;
          load_left  = ws_edge;
        end
        RIGHT: begin
          shift_en   = bclk_rise & ~ws_edge;
          word_close = ws_edge;
          load_pair  = ws_edge;
        end
        default: ;
      endcase
    end
    // IDLE, disable and every word boundary start the next word from an empty register
    word_clear = !enable || (state_q == IDLE) || word_close;
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------------------------

  // Insert the current bit at its left-aligned position; positions past WIDTH fall off
  always_comb begin
    bit_mask    = MSB_ONE >> cnt_q;
    word_next   = shift_q | (bit_mask & {WIDTH{sd_s}});
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    // A toggle right after a boundary closes an empty word: store zeros
    closed_word = (cnt_q == '0) ? '0 : word_next;
    closed_bad  = (cnt_inc != CNT_FULL);
  end

  // Next-state for the word registers, hold registers and output strobes
  always_comb begin
    ws_prev_d      = bclk_rise ? ws_s : ws_prev_q;
    shift_d        = shift_q;
    cnt_d          = cnt_q;
    left_hold_d    = left_hold_q;
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    valid_d        = 1'b0;
    err_d          = 1'b0;

    if (word_clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = word_next;
      cnt_d   = cnt_inc;
    end

    if (word_close) begin
      err_d = closed_bad;
    end
    if (load_left) begin
      left_hold_d = closed_word;
    end
    // Both channels update together, in the same cycle the valid strobe is raised
    if (load_pair) begin
      sample_left_d  = left_hold_q;
      sample_right_d = closed_word;
      valid_d        = 1'b1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_prev_q      <= 1'b0;
      shift_q        <= '0;
      cnt_q          <= '0;
      left_hold_q    <= '0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      valid_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      ws_prev_q      <= ws_prev_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      left_hold_q    <= left_hold_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      valid_q        <= valid_d;
      err_q          <= err_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: drives an I2S transmitter at clk/8, predicts outputs per word with a
// word-level model and checks them from an independent negedge monitor.
module tb_i2s_receiver;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         bit_clk;
  logic         frame_clk;
  logic         data;
  logic [W-1:0] sample_left;
  logic [W-1:0] sample_right;
  logic         sample_valid;
  logic         frame_err;

  // Scoreboard and model state
  exp_t         exp_q[$];
  bit           armed;
  logic [W-1:0] left_exp;
  int           left_err_exp;
  int           left_err_seen;
  logic [W-1:0] held_l;
  logic [W-1:0] held_r;
  int           tests;
  int           fails;
  bit           end_req;
  bit           done;

  i2s_receiver #(
    .WIDTH       (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .bit_clk      (bit_clk),
    .frame_clk    (frame_clk),
    .data         (data),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .frame_err    (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Received value of an n-bit word: first W bits kept, short words zero-padded at the LSB end
  function automatic logic [W-1:0] word_value(input int n, input logic [31:0] v);
    logic [31:0] t;
    if (n <= 1) return '0;
    if (n >= W) t = v >> (n - W);
    else        t = v << (W - n);
    return t[W-1:0];
  endfunction

  // Predict the effect of one complete word (its close happens at its last slot)
  task automatic model_word(input logic ch, input int n, input logic [31:0] v);
    logic [W-1:0] w;
    bit           bad;
    w   = word_value(n, v);
    bad = (n != W);
    if (!enable) begin
      armed = 1'b0;
    end else if (!armed) begin
      if (ch) armed = 1'b1;   // right->left boundary synchronises the receiver
    end else if (!ch) begin
      left_exp = w;
      if (bad) left_err_exp++;
    end else begin
      exp_q.push_back('{l: left_exp, r: w, err: bad});
    end
  endtask

  // One bit slot: data and word select change on the falling edge
  task automatic send_slot(input logic ws, input logic sd);
    bit_clk   = 1'b0;
    frame_clk = ws;
    data      = sd;
    #40;
    bit_clk = 1'b1;
    #40;
  endtask

  // n-bit word MSB first; the LSB slot already carries the next channel's word select
  task automatic send_word(input logic ch, input int n, input logic [31:0] v);
    logic [31:0] t;
    model_word(ch, n, v);
    for (int j = 0; j < n; j++) begin
      t = v >> (n - 1 - j);
      send_slot((j == n - 1) ? ~ch : ch, t[0]);
    end
  endtask

  task automatic send_frame(input logic [31:0] lv, input int ln, input logic [31:0] rv,
                            input int rn);
    send_word(1'b0, ln, lv);
    send_word(1'b1, rn, rv);
  endtask

  function automatic int rand_len();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(12, 18));
    return W;
  endfunction

  function automatic logic [31:0] rand_val(input int n);
    logic [31:0] v;
    v = $urandom;
    if (n < 32) v = v & ((32'd1 << n) - 32'd1);
    return v;
  endfunction

  task automatic send_random_frames(input int count);
    int ln;
    int rn;
    for (int k = 0; k < count; k++) begin
      ln = rand_len();
      rn = rand_len();
      send_frame(rand_val(ln), ln, rand_val(rn), rn);
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every clk against the scoreboard and the modelled held outputs
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_l = '0;
      held_r = '0;
      check("reset_outputs", 64'({sample_left, sample_right, sample_valid, frame_err}), 64'd0);
    end else if (sample_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got L=%h R=%h, expected no pulse at %0t",
                 sample_left, sample_right, $time);
      end else begin
        e = exp_q.pop_front();
        check("left", 64'(sample_left), 64'(e.l));
        check("right", 64'(sample_right), 64'(e.r));
        check("frame_err_with_valid", 64'(frame_err), 64'(e.err));
        held_l = e.l;
        held_r = e.r;
      end
    end else begin
      if (frame_err) left_err_seen++;
      check("hold", 64'({sample_left, sample_right}), 64'({held_l, held_r}));
    end
    if (end_req && !done) begin
      done = 1'b1;
      check("missing_valids", 64'(exp_q.size()), 64'd0);
      check("left_err_pulses", 64'(left_err_seen), 64'(left_err_exp));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2 ms");
    $fatal(1);
  end

  initial begin
    tests = 0; fails = 0; armed = 1'b0; left_exp = '0;
    left_err_exp = 0; left_err_seen = 0; end_req = 1'b0; done = 1'b0;
    held_l = '0; held_r = '0;
    reset = 1'b1; enable = 1'b1; bit_clk = 1'b0; frame_clk = 1'b0; data = 1'b0;
    #53 reset = 1'b0;
    #7;

    // Stream starts mid right-word: partial word only synchronises, never output
    send_word(1'b1, 9, 32'h1AB);
    send_frame(32'hA5C3, 16, 32'h0F0F, 16);

    // Back-to-back frames
    send_frame(32'h1234, 16, 32'h8765, 16);
    send_frame(32'hFFFF, 16, 32'h0000, 16);
    send_frame(32'h8000, 16, 32'h0001, 16);

    // Short and long right words
    send_frame(rand_val(16), 16, 32'hABC, 12);
    send_frame(rand_val(16), 16, rand_val(18), 18);

    send_random_frames(20);

    // Reset mid left-word, then restart mid right-word
    for (int j = 0; j < 6; j++) send_slot(1'b0, 1'($urandom));
    bit_clk = 1'b0;
    #3 reset = 1'b1;
    armed = 1'b0;
    exp_q.delete();
    #50 reset = 1'b0;
    #7;
    send_word(1'b1, 7, rand_val(7));
    send_random_frames(3);

    // Disabled for two frames, then a fresh lock-on
    enable = 1'b0;
    send_random_frames(2);
    enable = 1'b1;
    send_random_frames(3);

    send_random_frames(6);

    #1000;
    end_req = 1'b1;
  end

endmodule
